// File: rtl/ripple_count_monitor_if.sv
// Bus between the ripple-counter monitor and its system-side consumer.
// The master drives the raw count, the match value and the acknowledge.
// The slave (the monitor) returns the extended count, the event and the sticky flags.
interface ripple_count_monitor_if #(
  parameter int EXT_WIDTH = 8
);
  logic [3:0]           q_in;
  logic [3:0]           match_val;
  logic                 ev_ack;
  logic [EXT_WIDTH+3:0] count_out;
  logic                 ev_valid;
  logic [EXT_WIDTH+3:0] ev_count;
  logic                 skip_err;
  logic                 ev_ovf;

  modport master (
    output q_in,
    output match_val,
    output ev_ack,
    input  count_out,
    input  ev_valid,
    input  ev_count,
    input  skip_err,
    input  ev_ovf
  );

  modport slave (
    input  q_in,
    input  match_val,
    input  ev_ack,
    output count_out,
    output ev_valid,
    output ev_count,
    output skip_err,
    output ev_ovf
  );
endinterface

// File: rtl/ripple_count_monitor.sv
// Synchronous consumer of an asynchronously settling 4-bit ripple count.
// The raw count is double-flopped into the clk domain. A value is accepted
// only after it has held for STABLE_CYCLES edges. Accepted values are
// extended with a wrap counter, skipped steps are flagged, and a match
// against match_val raises a valid/ack event.
module ripple_count_monitor #(
  parameter int STABLE_CYCLES = 2,
  parameter int EXT_WIDTH     = 8
) (
  input logic                    clk,
  input logic                    reset,
  ripple_count_monitor_if.slave  bus
);

  localparam logic [3:0] STABLE_TARGET = 4'(STABLE_CYCLES);

  logic [3:0]           s1;
  logic [3:0]           s2;
  logic                 s1_vld;
  logic                 s2_vld;
  logic [3:0]           run_cnt;
  logic                 init_done;
  logic [3:0]           nibble;
  logic [EXT_WIDTH-1:0] wrap_cnt;
  logic                 ev_valid_r;
  logic [EXT_WIDTH+3:0] ev_count_r;
  logic                 skip_err_r;
  logic                 ev_ovf_r;

  logic                 s2_hold;
  logic                 accept;
  logic                 update;
  logic                 wrap_now;
  logic                 skip_now;
  logic                 match;
  logic [3:0]           step;
  logic [EXT_WIDTH-1:0] wrap_next;
  logic [EXT_WIDTH+3:0] count_next;

  // Decide what this edge does: hold/accept, wrap, skip and match detection.
  // The reset value of s2 is not a real sample, so s2 only counts as holding
  // once real data has propagated through both synchronizer flops.
  always_comb begin
    s2_hold    = 1'b0;
    accept     = 1'b0;
    update     = 1'b0;
    wrap_now   = 1'b0;
    skip_now   = 1'b0;
    match      = 1'b0;
    step       = 4'd0;
    wrap_next  = wrap_cnt;
    count_next = {wrap_cnt, nibble};

    s2_hold = s2_vld && (s1 == s2);
    accept  = s2_hold && (run_cnt == (STABLE_TARGET - 4'd1));
    step    = s2 - nibble;

    if (accept) begin
      if (!init_done) begin
        update = 1'b1;
      end else if (s2 != nibble) begin
        update   = 1'b1;
        wrap_now = (s2 < nibble);
        skip_now = (step > 4'd1);
      end
    end

    if (wrap_now) begin
      wrap_next = wrap_cnt + 1'b1;
    end
    count_next = {wrap_next, s2};
    match      = update && (s2 == bus.match_val);
  end

  // Two-flop synchronizer for the raw ripple count, with a valid trail
  // marking when real samples have reached each stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1     <= 4'd0;
      s2     <= 4'd0;
      s1_vld <= 1'b0;
      s2_vld <= 1'b0;
    end else begin
      s1     <= bus.q_in;
      s2     <= s1;
      s1_vld <= 1'b1;
      s2_vld <= s1_vld;
    end
  end

  // Stability run counter: restarts whenever s2 changes, saturates at the
  // target so a long-held value is accepted exactly once.
  always_ff @(posedge clk) begin
    if (reset) begin
      run_cnt <= 4'd0;
    end else if (!s2_hold) begin
      run_cnt <= 4'd0;
    end else if (run_cnt != STABLE_TARGET) begin
      run_cnt <= run_cnt + 4'd1;
    end
  end

  // Extended count and skip flag; the first acceptance only sets the baseline.
  always_ff @(posedge clk) begin
    if (reset) begin
      init_done  <= 1'b0;
      nibble     <= 4'd0;
      wrap_cnt   <= '0;
      skip_err_r <= 1'b0;
    end else if (update) begin
      init_done <= 1'b1;
      nibble    <= s2;
      wrap_cnt  <= wrap_next;
      if (skip_now) begin
        skip_err_r <= 1'b1;
      end
    end
  end

  // Event handshake: load on match when free or being acked, otherwise
  // record the drop; a plain ack retires the pending event.
  always_ff @(posedge clk) begin
    if (reset) begin
      ev_valid_r <= 1'b0;
      ev_count_r <= '0;
      ev_ovf_r   <= 1'b0;
    end else if (match) begin
      if (!ev_valid_r || bus.ev_ack) begin
        ev_valid_r <= 1'b1;
        ev_count_r <= count_next;
      end else begin
        ev_ovf_r <= 1'b1;
      end
    end else if (bus.ev_ack && ev_valid_r) begin
      ev_valid_r <= 1'b0;
    end
  end

  assign bus.count_out = {wrap_cnt, nibble};
  assign bus.ev_valid  = ev_valid_r;
  assign bus.ev_count  = ev_count_r;
  assign bus.skip_err  = skip_err_r;
  assign bus.ev_ovf    = ev_ovf_r;

endmodule
